grf_bypass_sb: RTL and testbench
================================

Name: grf_bypass_sb

Overview:
- Parametrised general-purpose register file for the pipelined core.
- Adds N combinational read ports, one write port, and write-to-read bypass, so a same-cycle write is visible on reads.
- Adds a per-register busy scoreboard for hazard detection.
- Sits in the decode stage; writeback drives the write port, issue logic drives the scoreboard set port.

Parameters:
- DW, 32, data width in bits.
- AW, 5, address width; depth = 2**AW registers.
- NUM_RD, 2, number of read ports (1..4).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- wr_en  input  1  write enable.
- wr_addr  input  AW  write address.
- wr_data  input  DW  write data.
- rd_addr  input  NUM_RD*AW  read addresses; port k occupies bits [k*AW +: AW].
- rd_data  output  NUM_RD*DW  read data; port k occupies bits [k*DW +: DW].
- rd_busy  output  NUM_RD  per-port flag: the addressed register has a pending producer.
- sb_set_en  input  1  mark a register busy (instruction issued with this destination).
- sb_set_addr  input  AW  register to mark busy.
- sb_clr_all  input  1  flush: clear all busy bits (pipeline flush).

Behaviour:
- Reset (reset==0, asynchronous):
  - All registers go to 0 and all busy bits go to 0.
  - rd_data reflects the cleared array immediately.
  - rd_busy goes to 0.
  - The block takes no action on clk while reset is low.
- Register 0 is hardwired:
  - Writes to address 0 are ignored.
  - sb_set_en with address 0 is ignored.
  - Reads of address 0 return 0 and rd_busy=0, regardless of bypass.
- Write: on posedge clk, if wr_en and wr_addr!=0, then reg[wr_addr] <= wr_data.
- Read is combinational, zero latency. For port k:
  - If rd_addr_k==0: rd_data_k=0.
  - Else if wr_en and wr_addr==rd_addr_k: rd_data_k=wr_data (bypass).
  - Else: rd_data_k=reg[rd_addr_k].
- Busy bits, updated on posedge clk in priority order:
  1. sb_clr_all clears every bit and overrides everything else in the same cycle.
  2. Otherwise, wr_en with wr_addr!=0 clears busy[wr_addr].
  3. Otherwise/additionally, sb_set_en with sb_set_addr!=0 sets busy[sb_set_addr].
  - If set and clear hit the same address in the same cycle, set wins (a new producer supersedes the retiring one). The bit ends 1.
- rd_busy_k:
  - Equals busy[rd_addr_k] & (rd_addr_k!=0).
  - Is masked to 0 when wr_en and wr_addr==rd_addr_k in that cycle, because bypass supplies the value.
  - Is not masked if sb_set_en targets the same address that cycle; the set takes effect next cycle.
- Writing a register whose busy bit is 0 is legal. The data is written and the busy bit stays 0.
- Multiple read ports may carry the same address; each port resolves independently and identically.
- No internal state machine beyond the array and the busy vector. All sequential elements use the same asynchronous reset.

Optional Feature:
- Macro: GRF_WRITE_TRACE_EN.
- Defined: adds output ports trace_valid (1), trace_addr (AW), trace_data (DW) and trace_cnt (16).
  - On each committed write (wr_en, wr_addr!=0), the next cycle shows trace_valid=1 with the registered address and data.
  - trace_cnt increments by 1 and wraps at 16'hFFFF -> 0.
  - Writes to address 0 do not trace.
  - Reset clears all trace outputs to 0.
- Not defined: the ports do not exist and no trace registers are synthesised.

Decomposition:
- Package grf_pkg holds:
  - Default DW/AW constants.
  - ZERO_REG = 0 constant.
  - Trace counter width constant TRACE_CW = 16.
- Sub-module grf_scoreboard holds:
  - The busy vector, with set/clear/flush priority logic.
  - Per-port rd_busy lookup, taking the write-port signals for masking.
- Top-level grf_bypass_sb holds the data array, bypass muxes and optional trace.

Test Plan:
- Reset and r0: hold reset=0 mid-run after writing reg[3]=32'hDEAD_BEEF, then release -> rd_data for addr 3 is 0 and rd_busy is 0. Then write addr 0 with 32'h1234 -> read addr 0 returns 0.
- Write/read: write reg[5]=32'hA5A5_0001 on cycle 1 -> port 0 addr 5 returns 32'hA5A5_0001 from cycle 2. Port 1 addr 6 stays 0.
- Bypass: in the same cycle wr_en=1, wr_addr=7, wr_data=32'h0000_00FF, with both ports addressing 7 -> both rd_data=32'h0000_00FF combinationally, before the clock edge.
- Scoreboard:
  - sb_set addr 9 -> rd_busy=1 next cycle.
  - Write addr 9 -> rd_busy=0 during the write cycle (masked) and stays 0 after.
  - Set and write addr 9 in the same cycle -> busy=1 afterwards.
- Flush: set busy on addrs 2, 4, 31, then pulse sb_clr_all while sb_set_en targets 4 -> all busy bits 0 next cycle.
- Trace (GRF_WRITE_TRACE_EN): three writes to addrs 1, 0, 2 -> exactly two trace_valid pulses with addrs 1 and 2, and trace_cnt=2. Preload the counter to 16'hFFFF with one more write -> trace_cnt wraps to 0.

Source files
------------

// File: rtl/grf_pkg.sv
// Shared constants for the general-purpose register file with bypass and scoreboard.
//   DW_DEF / AW_DEF : default data / address widths
//   ZERO_REG        : hardwired-zero register index
//   TRACE_CW        : width of the optional write-trace counter
package grf_pkg;

  localparam int unsigned DW_DEF   = 32;
  localparam int unsigned AW_DEF   = 5;
  localparam int unsigned ZERO_REG = 0;
  localparam int unsigned TRACE_CW = 16;

endpackage

// File: rtl/grf_scoreboard.sv
// Per-register busy scoreboard used for hazard detection in decode.
// Ports:
//   clk, reset             : clock, asynchronous active-low reset
//   wr_en, wr_addr         : writeback port; retires the producer of wr_addr
//   sb_set_en, sb_set_addr : issue marks a destination busy
//   sb_clr_all             : flush, clears every busy bit (highest priority)
//   rd_addr                : packed read addresses, port k at [k*AW +: AW]
//   rd_busy                : per-port busy flag, masked when bypass supplies the value
module grf_scoreboard
  import grf_pkg::*;
#(
  parameter int unsigned AW     = AW_DEF,
  parameter int unsigned NUM_RD = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic                 sb_set_en,
  input  logic [AW-1:0]        sb_set_addr,
  input  logic                 sb_clr_all,
  input  logic [NUM_RD*AW-1:0] rd_addr,
  output logic [NUM_RD-1:0]    rd_busy
);

  localparam int unsigned Depth = 1 << AW;

  logic [Depth-1:0] busy_q, busy_d;
  logic             wr_commit, set_commit;

  assign wr_commit  = wr_en && (wr_addr != AW'(ZERO_REG));
  assign set_commit = sb_set_en && (sb_set_addr != AW'(ZERO_REG));

  // Clear is applied before set so a same-cycle set on the retiring address wins.
  always_comb begin
    busy_d = busy_q;
    if (sb_clr_all) begin
      busy_d = '0;
    end else begin
      if (wr_commit)  busy_d[wr_addr]     = 1'b0;
      if (set_commit) busy_d[sb_set_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // A same-cycle write to the read address means bypass already supplies the value.
  always_comb begin
    rd_busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_busy[k] = busy_q[rd_addr[k*AW +: AW]]
                   && (rd_addr[k*AW +: AW] != AW'(ZERO_REG))
                   && !(wr_en && (wr_addr == rd_addr[k*AW +: AW]));
    end
  end

endmodule

// File: rtl/grf_bypass_sb.sv
// General-purpose register file: NUM_RD combinational read ports, one write port,
// write-to-read bypass, and a per-register busy scoreboard. Register 0 reads as zero.
// Ports:
//   clk, reset             : clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data  : writeback port
//   rd_addr / rd_data      : packed read ports, port k at [k*AW +: AW] / [k*DW +: DW]
//   rd_busy                : per-port pending-producer flag
//   sb_set_en/sb_set_addr  : issue marks a destination busy
//   sb_clr_all             : pipeline flush of all busy bits
// Optional (macro GRF_WRITE_TRACE_EN):
//   trace_valid/trace_addr/trace_data : registered copy of each committed write
//   trace_cnt                         : wrapping count of committed writes
module grf_bypass_sb
  import grf_pkg::*;
#(
  parameter int unsigned DW     = DW_DEF,
  parameter int unsigned AW     = AW_DEF,
  parameter int unsigned NUM_RD = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [DW-1:0]        wr_data,
  input  logic [NUM_RD*AW-1:0] rd_addr,
  output logic [NUM_RD*DW-1:0] rd_data,
  output logic [NUM_RD-1:0]    rd_busy,
  input  logic                 sb_set_en,
  input  logic [AW-1:0]        sb_set_addr,
  input  logic                 sb_clr_all
`ifdef GRF_WRITE_TRACE_EN
  ,
  output logic                 trace_valid,
  output logic [AW-1:0]        trace_addr,
  output logic [DW-1:0]        trace_data,
  output logic [TRACE_CW-1:0]  trace_cnt
`endif
);

  localparam int unsigned Depth = 1 << AW;

  logic [DW-1:0] mem_q [Depth];
  logic          wr_commit;

  assign wr_commit = wr_en && (wr_addr != AW'(ZERO_REG));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else if (wr_commit) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Register 0 wins over bypass so an ignored write to r0 never leaks through.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (rd_addr[k*AW +: AW] == AW'(ZERO_REG)) begin
        rd_data[k*DW +: DW] = '0;
      end else if (wr_en && (wr_addr == rd_addr[k*AW +: AW])) begin
        rd_data[k*DW +: DW] = wr_data;
      end else begin
        rd_data[k*DW +: DW] = mem_q[rd_addr[k*AW +: AW]];
      end
    end
  end

  grf_scoreboard #(
    .AW     (AW),
    .NUM_RD (NUM_RD)
  ) u_scoreboard (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .sb_set_en   (sb_set_en),
    .sb_set_addr (sb_set_addr),
    .sb_clr_all  (sb_clr_all),
    .rd_addr     (rd_addr),
    .rd_busy     (rd_busy)
  );

`ifdef GRF_WRITE_TRACE_EN
  logic                trace_valid_q;
  logic [AW-1:0]       trace_addr_q;
  logic [DW-1:0]       trace_data_q;
  logic [TRACE_CW-1:0] trace_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trace_valid_q <= 1'b0;
      trace_addr_q  <= '0;
      trace_data_q  <= '0;
      trace_cnt_q   <= '0;
    end else begin
      trace_valid_q <= wr_commit;
      if (wr_commit) begin
        trace_addr_q <= wr_addr;
        trace_data_q <= wr_data;
        trace_cnt_q  <= trace_cnt_q + TRACE_CW'(1);
      end
    end
  end

  assign trace_valid = trace_valid_q;
  assign trace_addr  = trace_addr_q;
  assign trace_data  = trace_data_q;
  assign trace_cnt   = trace_cnt_q;
`endif

endmodule

// File: tb/tb_grf_bypass_sb.sv
// Self-checking bench for grf_bypass_sb: directed scenarios followed by randomized
// traffic, all compared against a behavioural register/busy model kept here.
module tb_grf_bypass_sb;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 2;

  logic              clk;
  logic              reset;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data;
  logic [NR-1:0]     rd_busy;
  logic              sb_set_en;
  logic [AW-1:0]     sb_set_addr;
  logic              sb_clr_all;
`ifdef GRF_WRITE_TRACE_EN
  logic              trace_valid;
  logic [AW-1:0]     trace_addr;
  logic [DW-1:0]     trace_data;
  logic [15:0]       trace_cnt;
`endif

  grf_bypass_sb #(
    .DW     (DW),
    .AW     (AW),
    .NUM_RD (NR)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_busy     (rd_busy),
    .sb_set_en   (sb_set_en),
    .sb_set_addr (sb_set_addr),
    .sb_clr_all  (sb_clr_all)
`ifdef GRF_WRITE_TRACE_EN
    ,
    .trace_valid (trace_valid),
    .trace_addr  (trace_addr),
    .trace_data  (trace_data),
    .trace_cnt   (trace_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model: register contents and busy flags, indexed by address.
  logic [DW-1:0] mreg  [32];
  bit            mbusy [32];
  bit            exp_tv;
  logic [AW-1:0] exp_ta;
  logic [DW-1:0] exp_td;
  logic [15:0]   exp_tc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      mreg[i]  = '0;
      mbusy[i] = 1'b0;
    end
    exp_tv = 1'b0;
    exp_ta = '0;
    exp_td = '0;
    exp_tc = '0;
  endtask

  function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (wr_en && wr_addr == a) return wr_data;
    return mreg[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    return (a != 0) && mbusy[a] && !(wr_en && wr_addr == a);
  endfunction

  // Applies the clock-edge rules to the model using the inputs held across the edge.
  task automatic model_edge();
    bit commit;
    commit = wr_en && (wr_addr != 0);
    if (commit) mreg[wr_addr] = wr_data;
    if (sb_clr_all) begin
      for (int i = 0; i < 32; i++) mbusy[i] = 1'b0;
    end else begin
      if (commit) mbusy[wr_addr] = 1'b0;
      if (sb_set_en && sb_set_addr != 0) mbusy[sb_set_addr] = 1'b1;
    end
    exp_tv = commit;
    if (commit) begin
      exp_ta = wr_addr;
      exp_td = wr_data;
      exp_tc = exp_tc + 16'd1;
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < NR; k++) begin
      chk({tag, "_data"}, 64'(rd_data[k*DW +: DW]), 64'(exp_data(rd_addr[k*AW +: AW])));
      chk({tag, "_busy"}, 64'(rd_busy[k]), 64'(exp_busy(rd_addr[k*AW +: AW])));
    end
`ifdef GRF_WRITE_TRACE_EN
    chk({tag, "_tv"}, 64'(trace_valid), 64'(exp_tv));
    chk({tag, "_tc"}, 64'(trace_cnt), 64'(exp_tc));
    if (exp_tv) begin
      chk({tag, "_ta"}, 64'(trace_addr), 64'(exp_ta));
      chk({tag, "_td"}, 64'(trace_data), 64'(exp_td));
    end
`endif
  endtask

  task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic se, input logic [AW-1:0] sa, input logic clr,
                       input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
    wr_en       = we;
    wr_addr     = wa;
    wr_data     = wd;
    sb_set_en   = se;
    sb_set_addr = sa;
    sb_clr_all  = clr;
    rd_addr     = {ra1, ra0};
  endtask

  // Inputs are set at posedge+1; outputs checked at posedge+4; then the edge is taken.
  task automatic cycle(input string tag);
    #3;
    check_all(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    logic [AW-1:0] wa, ra0, ra1;
    model_reset();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 5'd3, 5'd6);
    #8;
    chk("rst_data0", 64'(rd_data[31:0]), 64'h0);
    chk("rst_busy",  64'(rd_busy), 64'h0);
    #8;
    reset = 1'b1;

    // Write r3 and mark it busy, then assert reset mid-run.
    drive(1, 5'd3, 32'hDEAD_BEEF, 0, 0, 0, 5'd3, 5'd0);  cycle("w3");
    drive(0, 0, 0, 1, 5'd3, 0, 5'd3, 5'd0);              cycle("set3");
    drive(0, 0, 0, 0, 0, 0, 5'd3, 5'd0);                 cycle("rd3");
    chk("pre_rst3", 64'(rd_data[31:0]), 64'hDEAD_BEEF);
    reset = 1'b0;
    #2;
    model_reset();
    chk("async_rst3", 64'(rd_data[31:0]), 64'h0);
    chk("async_rstb", 64'(rd_busy[0]), 64'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    cycle("post_rst");

    // Writes to r0 are dropped.
    drive(1, 5'd0, 32'h1234, 1, 5'd0, 0, 5'd0, 5'd0);    cycle("w0");
    drive(0, 0, 0, 0, 0, 0, 5'd0, 5'd0);                 #3;
    chk("r0_zero", 64'(rd_data), 64'h0);
    chk("r0_busy", 64'(rd_busy), 64'h0);
    cycle("r0");

    // Write/read.
    drive(1, 5'd5, 32'hA5A5_0001, 0, 0, 0, 5'd1, 5'd6);  cycle("w5");
    drive(0, 0, 0, 0, 0, 0, 5'd5, 5'd6);                 #3;
    chk("rd5", 64'(rd_data[31:0]), 64'hA5A5_0001);
    chk("rd6", 64'(rd_data[63:32]), 64'h0);
    cycle("rd56");

    // Bypass on both ports before the edge.
    drive(1, 5'd7, 32'h0000_00FF, 0, 0, 0, 5'd7, 5'd7);  #3;
    chk("byp_p0", 64'(rd_data[31:0]), 64'hFF);
    chk("byp_p1", 64'(rd_data[63:32]), 64'hFF);
    cycle("byp");

    // Scoreboard set, masked-by-write, set+write same cycle.
    drive(0, 0, 0, 1, 5'd9, 0, 5'd9, 5'd9);              #3;
    chk("set9_same", 64'(rd_busy[0]), 64'h0);
    cycle("set9");
    drive(0, 0, 0, 0, 0, 0, 5'd9, 5'd9);                 #3;
    chk("busy9", 64'(rd_busy), 64'h3);
    cycle("busy9c");
    drive(1, 5'd9, 32'h99, 0, 0, 0, 5'd9, 5'd9);         #3;
    chk("mask9", 64'(rd_busy), 64'h0);
    cycle("mask9c");
    drive(0, 0, 0, 0, 0, 0, 5'd9, 5'd9);                 #3;
    chk("clr9", 64'(rd_busy), 64'h0);
    cycle("clr9c");
    drive(1, 5'd9, 32'h9A, 1, 5'd9, 0, 5'd9, 5'd8);      cycle("setwr9");
    drive(0, 0, 0, 0, 0, 0, 5'd9, 5'd8);                 #3;
    chk("setwins9", 64'(rd_busy[0]), 64'h1);
    cycle("setwins9c");

    // Flush overrides a same-cycle set.
    drive(0, 0, 0, 1, 5'd2, 0, 5'd2, 5'd4);              cycle("set2");
    drive(0, 0, 0, 1, 5'd4, 0, 5'd2, 5'd4);              cycle("set4");
    drive(0, 0, 0, 1, 5'd31, 0, 5'd31, 5'd4);            cycle("set31");
    drive(0, 0, 0, 1, 5'd4, 1, 5'd2, 5'd31);             cycle("flush");
    drive(0, 0, 0, 0, 0, 0, 5'd2, 5'd4);                 #3;
    chk("flush24", 64'(rd_busy), 64'h0);
    cycle("flushc");
    drive(0, 0, 0, 0, 0, 0, 5'd31, 5'd9);                #3;
    chk("flush31_9", 64'(rd_busy), 64'h0);
    cycle("flushc2");

    // Randomized traffic; read addresses biased toward the write address and low regs.
    for (int n = 0; n < 400; n++) begin
      wa  = 5'($urandom_range(0, 31));
      ra0 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 7));
      ra1 = ($urandom_range(0, 3) == 0) ? ra0 : 5'($urandom_range(0, 31));
      drive(1'($urandom_range(0, 1)), wa, $urandom,
            1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 7)),
            ($urandom_range(0, 15) == 0), ra0, ra1);
      cycle("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
